fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-prefetch stage that replaces the single-register fetch stage of the 4-stage RISC-V pipeline. It owns the PC, issues one word request per cycle to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry circular queue. Decode consumes them through a valid/ready handshake. A redirect from Exec (taken jump or branch) flushes the queue and any in-flight response and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: value driven on out_instr while out_valid=0.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect  in  1  jump_enable from Exec; flush and refetch.
- redirect_addr  in  32  jump_address from Exec; word-aligned.
- req_valid  out  1  instruction-memory read request.
- req_addr  out  32  request address.
- rsp_instr  in  32  memory data, valid exactly 1 cycle after an accepted request.
- out_valid  out  1  queue head is valid.
- out_instr  out  32  head instruction, or NOP_INSTR when out_valid=0.
- out_pc  out  32  head PC; don't-care when out_valid=0.
- out_ready  in  1  Decode accepts the head; low means stall.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

## Operation
- State:
  - fetch_pc
  - queue storage, with rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap naturally
  - count
  - inflight (1 bit): request issued last cycle
  - inflight_pc
  - drop (1 bit): discard the next response
- Pop = out_valid & out_ready & !redirect.
- Push happens when inflight & !drop & !redirect. It writes {rsp_instr, inflight_pc} at wr_ptr.
- Issue condition without redirect: count + inflight − pop < DEPTH. When it holds:
  - req_valid=1, req_addr=fetch_pc
  - fetch_pc += 4, modulo 2^32
  - inflight ← 1, inflight_pc ← fetch_pc
- Otherwise inflight ← 0 and fetch_pc holds.
- Because of the issue condition, a push never meets a full queue. Overflow is impossible by construction, and the bench asserts it.
- Redirect (highest priority):
  - count, rd_ptr and wr_ptr clear.
  - Any response arriving this cycle is discarded. An out_ready pop is ignored.
  - req_valid=1, req_addr=redirect_addr in the same cycle.
  - fetch_pc ← redirect_addr+4, inflight ← 1, inflight_pc ← redirect_addr, drop ← 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset is asynchronous and may assert mid-operation:
  - fetch_pc=RESET_PC, count=0, pointers 0, inflight=0, drop=0.
  - Outputs during reset: req_valid=0, out_valid=0, out_instr=NOP_INSTR, occupancy=0.
  - A memory response pending at reset assertion is never enqueued.

## Timing
- The first rising edge after rst_n deasserts issues the request for RESET_PC. Its instruction appears at the head 2 edges after issue.
- Request-to-head latency: 2 cycles. Redirect-to-target-at-head: 2 cycles.
- Sustained throughput: 1 instruction per cycle when out_ready=1.
- With out_ready held low, the queue fills to DEPTH and req_valid then stays 0. At most DEPTH requests are outstanding plus stored.
- When out_ready rises at full, issue resumes in that same cycle, because pop frees a slot.
- out_valid and out_instr/out_pc come straight from registered queue state (count, head entry). They have no combinational path from out_ready or rsp_instr.
- occupancy is registered.

## Test plan
- Reset, then out_ready=1 with memory mem[a]=a|1: req_addr sequence 0,4,8,…, one per cycle. The first out_valid appears 2 cycles after the first request. The out_pc/out_instr pairs are (0,1),(4,5),(8,9) with no bubbles.
- out_ready=0 for 10 cycles, DEPTH=4: occupancy reaches 4 and req_valid goes low. No PC is lost or duplicated. After out_ready=1, the stream continues contiguously through pointer wrap-around.
- Redirect to 0x100 while the queue holds 3 entries and a request is in flight: occupancy becomes 0 on the next edge. The stale response is dropped. The next head is (0x100, mem[0x100]) 2 cycles later.
- Redirect in the same cycle as a pop and a push: neither takes effect, and the queue is empty afterwards.
- rst_n asserted mid-stream with 2 entries queued: all outputs immediately go to reset values. After release, fetch restarts at RESET_PC.
- DEPTH=2 and DEPTH=8 builds: the 1-per-cycle throughput and full-stall scenarios both pass.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the PC, issues one read per cycle to a synchronous-read
// instruction memory and buffers {instr, pc} pairs in a circular queue for Decode.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [31:0]              redirect_addr,
    output logic                     req_valid,
    output logic [31:0]              req_addr,
    input  logic [31:0]              rsp_instr,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = CW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;

    logic          pop;
    logic          push;
    logic          issue;
    logic [LW-1:0] level;

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? q_instr[rd_ptr_q] : NOP_INSTR;
    assign out_pc    = q_pc[rd_ptr_q];
    assign occupancy = count_q;

    assign pop  = out_valid & out_ready & ~redirect;
    assign push = inflight_q & ~drop_q & ~redirect;

    // Slots already committed (stored + in flight) after this cycle's pop; never underflows
    // because pop implies count_q >= 1.
    assign level = LW'(count_q) + LW'(inflight_q) - LW'(pop);
    assign issue = (level < DEPTH_L);

    // rst_n gating keeps the request quiet while reset is held.
    assign req_valid = rst_n & (redirect | issue);
    assign req_addr  = redirect ? redirect_addr : fetch_pc_q;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        if (redirect) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            fetch_pc_d    = redirect_addr + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_addr;
            drop_d        = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            drop_q        <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr_q] <= rsp_instr;
            q_pc[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=4 main instance plus DEPTH=2 and DEPTH=8 instances
// sharing the same stimulus for the throughput and full-stall scenarios.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        out_ready = 1'b0;

    logic        rv4, ov4, rv2, ov2, rv8, ov8;
    logic [31:0] ra4, ri4, oi4, op4;
    logic [31:0] ra2, ri2, oi2, op2;
    logic [31:0] ra8, ri8, oi8, op8;
    logic [2:0]  occ4;
    logic [1:0]  occ2;
    logic [3:0]  occ8;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
        .req_valid(rv4), .req_addr(ra4), .rsp_instr(ri4), .out_valid(ov4),
        .out_instr(oi4), .out_pc(op4), .out_ready(out_ready), .occupancy(occ4)
    );
    fetch_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
        .req_valid(rv2), .req_addr(ra2), .rsp_instr(ri2), .out_valid(ov2),
        .out_instr(oi2), .out_pc(op2), .out_ready(out_ready), .occupancy(occ2)
    );
    fetch_queue #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
        .req_valid(rv8), .req_addr(ra8), .rsp_instr(ri8), .out_valid(ov8),
        .out_instr(oi8), .out_pc(op8), .out_ready(out_ready), .occupancy(occ8)
    );

    // Synchronous-read memory models: mem[a] = a | 1.
    always @(posedge clk) begin
        if (rv4) ri4 <= ra4 | 32'h1;
        if (rv2) ri2 <= ra2 | 32'h1;
        if (rv8) ri8 <= ra8 | 32'h1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] ra);
        @(negedge clk);
        out_ready = rdy;
        redirect = rd;
        redirect_addr = ra;
        #1;
        chk("occ_bound", 32'(occ4 <= 3'd4), 32'd1);
    endtask

    task automatic head4(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(ov4), 32'd1);
        chk({tag, "_pc"}, op4, pc);
        chk({tag, "_instr"}, oi4, pc | 32'h1);
    endtask

    initial begin
        // Reset values while rst_n is held low.
        #2;
        chk("rst_req_valid", 32'(rv4), 32'd0);
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_out_instr", oi4, 32'h13);
        chk("rst_occ", 32'(occ4), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("first_req_valid", 32'(rv4), 32'd1);
        chk("first_req_addr", ra4, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("no_head_yet", 32'(ov4), 32'd0);
        chk("no_head_instr", oi4, 32'h13);
        chk("second_req_addr", ra4, 32'h4);

        // Back-to-back streaming: heads 0,4,8,... with no bubbles.
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            head4("stream", 32'(4 * k));
            chk("stream_req_addr", ra4, 32'(4 * k + 8));
            chk("stream_pc_d2", op2, 32'(4 * k));
            chk("stream_pc_d8", op8, 32'(4 * k));
        end

        // Stall: queue fills with 24,28,32,36; requests stop.
        for (int s = 0; s < 10; s++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (s == 1) chk("stall_s1_req", 32'(rv4), 32'd1);
            if (s == 2) begin
                chk("stall_s2_occ", 32'(occ4), 32'd3);
                chk("stall_s2_req", 32'(rv4), 32'd0);
            end
        end
        chk("full_occ4", 32'(occ4), 32'd4);
        chk("full_req4", 32'(rv4), 32'd0);
        chk("full_occ2", 32'(occ2), 32'd2);
        chk("full_req2", 32'(rv2), 32'd0);
        chk("full_occ8", 32'(occ8), 32'd8);
        chk("full_req8", 32'(rv8), 32'd0);
        head4("stall_head", 32'd24);

        // Release at full: issue resumes in the same cycle, stream stays contiguous.
        cyc(1'b1, 1'b0, 32'h0);
        chk("resume_req_valid", 32'(rv4), 32'd1);
        chk("resume_req_addr", ra4, 32'd40);
        chk("resume_req_d2", 32'(rv2), 32'd1);
        chk("resume_req_d8", 32'(rv8), 32'd1);
        head4("resume", 32'd24);
        for (int j = 1; j < 10; j++) begin
            cyc(1'b1, 1'b0, 32'h0);
            head4("wrap", 32'(24 + 4 * j));
            chk("wrap_pc_d2", op2, 32'(24 + 4 * j));
            chk("wrap_pc_d8", op8, 32'(24 + 4 * j));
        end

        // Redirect with 3 entries queued and one request in flight.
        cyc(1'b0, 1'b1, 32'h100);
        chk("redir_occ_before", 32'(occ4), 32'd3);
        chk("redir_req_valid", 32'(rv4), 32'd1);
        chk("redir_req_addr", ra4, 32'h100);
        cyc(1'b1, 1'b0, 32'h0);
        chk("redir_occ_after", 32'(occ4), 32'd0);
        chk("redir_out_valid", 32'(ov4), 32'd0);
        chk("redir_out_instr", oi4, 32'h13);
        chk("redir_next_addr", ra4, 32'h104);
        cyc(1'b1, 1'b0, 32'h0);
        head4("redir_tgt", 32'h100);
        cyc(1'b1, 1'b0, 32'h0);
        head4("redir_tgt2", 32'h104);

        // Redirect colliding with a pop and a push.
        cyc(1'b1, 1'b1, 32'h200);
        head4("coll_head", 32'h108);
        chk("coll_occ_before", 32'(occ4), 32'd1);
        cyc(1'b1, 1'b0, 32'h0);
        chk("coll_occ_after", 32'(occ4), 32'd0);
        chk("coll_out_valid", 32'(ov4), 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        head4("coll_tgt", 32'h200);

        // Mid-stream asynchronous reset with 2 entries queued.
        cyc(1'b0, 1'b0, 32'h0);
        head4("pre_rst", 32'h204);
        cyc(1'b0, 1'b0, 32'h0);
        chk("pre_rst_occ", 32'(occ4), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(rv4), 32'd0);
        chk("async_rst_valid", 32'(ov4), 32'd0);
        chk("async_rst_instr", oi4, 32'h13);
        chk("async_rst_occ", 32'(occ4), 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("held_rst_occ", 32'(occ4), 32'd0);
        chk("held_rst_req", 32'(rv4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_req_valid", 32'(rv4), 32'd1);
        chk("restart_req_addr", ra4, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("restart_empty", 32'(ov4), 32'd0);
        cyc(1'b1, 1'b0, 32'h0);
        head4("restart0", 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        head4("restart1", 32'h4);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
